plab5_mcore_mem_acc_tagged: RTL and testbench
=============================================

PLAB5_MCORE_MEM_ACC_TAGGED -- requirements
Module: plab5_mcore_mem_acc_tagged

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8: memory message opaque field width (o).
REQ-002 SHALL have parameter p_addr_nbits, default 32: address field width (a).
REQ-003 SHALL have parameter p_data_nbits, default 32: data field width (d).
REQ-004 SHALL have parameter p_lvl_nbits, default 2: security level width (l); higher value means more trusted.
REQ-005 SHALL have parameter p_pend_depth, default 4: pending-transaction FIFO depth, a power of two, at least 2.
REQ-006 SHALL have ports, with clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_sec_level  in  l  level of the requester on net_req.
- mem_sec_level  in  l  level of the protected memory.
- net_req_control  in  3+o+a+2  {type[2:0], opaque, addr, len[1:0]}, MSB to LSB.
- net_req_data  in  d  request data.
- net_req_val  in  1  request valid.
- net_req_rdy  out  1  request ready.
- mem_req_control  out  3+o+a+2  forwarded request control.
- mem_req_data  out  d  forwarded request data.
- mem_req_val  out  1  forwarded request valid.
- mem_req_rdy  in  1  memory ready.
- mem_resp_control  in  3+o+2  {type, opaque, len}.
- mem_resp_data  in  d  memory response data.
- mem_resp_val  in  1  memory response valid.
- mem_resp_rdy  out  1  memory response ready.
- net_resp_control  out  3+o+2  response control.
- net_resp_data  out  d  response data.
- net_resp_val  out  1  response valid.
- net_resp_rdy  in  1  network ready.
- resp_sec_level  out  l  level of the transaction at the head of the FIFO.
- viol_count  out  16  saturating count of denied requests.
- viol_flag  out  1  sticky flag; set by a denial or by an orphan response.
- viol_clear  in  1  synchronous clear of viol_count and viol_flag.

Function
REQ-007 SHALL grant a request iff req_sec_level >= mem_sec_level (unsigned compare); the decision SHALL be evaluated in the cycle the request is accepted.
REQ-008 SHALL hold a FIFO of p_pend_depth entries, each {granted, level, type, opaque, len}; the entry SHALL be pushed on net_req fire (net_req_val && net_req_rdy).
REQ-009 SHALL drive net_req_rdy = !full && (!granted || mem_req_rdy).
REQ-010 SHALL drive mem_req_val = net_req_val && granted && !full; on a grant, mem_req_control/data SHALL equal net_req_control/data.
REQ-011 SHALL drive, on a denial, mem_req_val=0, mem_req_control=0 and mem_req_data=0; the memory SHALL never observe a denied request.
REQ-012 SHALL, when the head entry is granted, pass mem_resp_* through to net_resp_*, with mem_resp_rdy = net_resp_rdy.
REQ-013 SHALL, when the head entry is denied:
- drive net_resp_val=1, net_resp_control={head.type, head.opaque, head.len} and net_resp_data=0;
- drive mem_resp_rdy=0.
REQ-014 SHALL pop the head on net_resp fire; responses SHALL return strictly in request order, denials included.
REQ-015 SHALL drive net_resp_val=0 and net_resp_data=0 when the FIFO is empty, and resp_sec_level SHALL then be 0.
REQ-016 SHALL, when the FIFO is empty, hold mem_resp_rdy=0 and set viol_flag on any mem_resp_val (orphan response).
REQ-017 SHALL, with the FIFO full and a pop in the same cycle, still hold net_req_rdy=0 (no bypass).
REQ-018 SHALL keep occupancy in a counter of clog2(p_pend_depth)+1 bits; read and write pointers SHALL wrap modulo p_pend_depth.
REQ-019 SHALL increment viol_count once per denied fire and saturate at 16'hFFFF.
REQ-020 SHALL give viol_clear priority over a same-cycle increment: both viol_count and viol_flag SHALL read 0 on the next cycle.
REQ-021 SHALL apply a change of mem_sec_level only to later requests; FIFO entries already pushed SHALL be unaffected.
REQ-022 SHALL have zero-cycle latency on the request path and the granted response path (combinational); a denial response SHALL become valid in the cycle its entry reaches the head.

Reset
REQ-023 SHALL, on reset assertion and asynchronously:
- empty the FIFO and clear both pointers;
- clear viol_count and viol_flag;
- force net_resp_val, mem_req_val and mem_resp_rdy to 0.
REQ-024 SHALL drop in-flight transactions when reset is asserted mid-operation; after reset, no response SHALL be produced for them.

Verification
REQ-025 Equal levels: req 1/mem 1, read opaque 0x05 -> memory sees the request; mem response data 0xCAFE returned with opaque 0x05; resp_sec_level=1.
REQ-026 Low requester: req 0/mem 2, write opaque 0x11 -> mem_req_val stays 0; net_resp_val=1 with opaque 0x11 and data 0 on the next cycle; viol_count=1; viol_flag=1.
REQ-027 Ordering: granted A (0x01), denied B (0x02), granted C (0x03) -> network receives 0x01, 0x02, 0x03 in order, even if the memory stalls A by 5 cycles.
REQ-028 Full FIFO: depth 4, four granted requests with net_resp_rdy=0 -> fifth request sees net_req_rdy=0, including during the cycle of the first pop.
REQ-029 Saturation and clear: 65537 denials -> viol_count=16'hFFFF; viol_clear together with a denial -> viol_count=0 next cycle.
REQ-030 Reset mid-flight: two pending requests, then reset -> net_resp_val=0 immediately; a later mem_resp_val raises viol_flag and mem_resp_rdy stays 0.

Source files
------------

// File: rtl/plab5_mcore_mem_acc_tagged.sv
// Security-tagged memory access gate: grants or denies each request by level and
// returns responses strictly in request order, synthesizing replies for denials.
module plab5_mcore_mem_acc_tagged #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_lvl_nbits    = 2,
  parameter int p_pend_depth   = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [p_lvl_nbits-1:0]                   req_sec_level,
  input  logic [p_lvl_nbits-1:0]                   mem_sec_level,
  input  logic [3+p_opaque_nbits+p_addr_nbits+2-1:0] net_req_control,
  input  logic [p_data_nbits-1:0]                  net_req_data,
  input  logic                                     net_req_val,
  output logic                                     net_req_rdy,
  output logic [3+p_opaque_nbits+p_addr_nbits+2-1:0] mem_req_control,
  output logic [p_data_nbits-1:0]                  mem_req_data,
  output logic                                     mem_req_val,
  input  logic                                     mem_req_rdy,
  input  logic [3+p_opaque_nbits+2-1:0]            mem_resp_control,
  input  logic [p_data_nbits-1:0]                  mem_resp_data,
  input  logic                                     mem_resp_val,
  output logic                                     mem_resp_rdy,
  output logic [3+p_opaque_nbits+2-1:0]            net_resp_control,
  output logic [p_data_nbits-1:0]                  net_resp_data,
  output logic                                     net_resp_val,
  input  logic                                     net_resp_rdy,
  output logic [p_lvl_nbits-1:0]                   resp_sec_level,
  output logic [15:0]                              viol_count,
  output logic                                     viol_flag,
  input  logic                                     viol_clear
);

  localparam int CW = 3 + p_opaque_nbits + p_addr_nbits + 2;
  localparam int PW = $clog2(p_pend_depth);

  typedef struct packed {
    logic                      granted;
    logic [p_lvl_nbits-1:0]    level;
    logic [2:0]                typ;
    logic [p_opaque_nbits-1:0] opaque;
    logic [1:0]                len;
  } entry_t;

  entry_t        fifo_q [p_pend_depth];
  entry_t        entry_new;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [15:0]   viol_count_q, viol_count_d;
  logic          viol_flag_q, viol_flag_d;

  logic granted, full, empty, push, pop, deny_fire, orphan;

  // Request path: the grant decision uses the levels present in the accept cycle.
  always_comb begin
    granted   = req_sec_level >= mem_sec_level;
    full      = cnt_q == (PW+1)'(p_pend_depth);
    empty     = cnt_q == '0;
    net_req_rdy     = !reset && !full && (!granted || mem_req_rdy);
    mem_req_val     = !reset && net_req_val && granted && !full;
    mem_req_control = granted ? net_req_control : '0;
    mem_req_data    = granted ? net_req_data    : '0;
    push      = net_req_val && net_req_rdy;
    deny_fire = push && !granted;
    entry_new = '{granted: granted,
                  level:   req_sec_level,
                  typ:     net_req_control[CW-1 -: 3],
                  opaque:  net_req_control[p_addr_nbits+2 +: p_opaque_nbits],
                  len:     net_req_control[1:0]};
  end

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    head             = fifo_q[rd_ptr_q];
    net_resp_val     = 1'b0;
    net_resp_control = '0;
    net_resp_data    = '0;
    mem_resp_rdy     = 1'b0;
    resp_sec_level   = '0;
    if (!empty) begin
      resp_sec_level = head.level;
      if (head.granted) begin
        net_resp_val     = mem_resp_val;
        net_resp_control = mem_resp_control;
        net_resp_data    = mem_resp_data;
        mem_resp_rdy     = net_resp_rdy;
      end else begin
        net_resp_val     = 1'b1;
        net_resp_control = {head.typ, head.opaque, head.len};
      end
    end
    pop    = net_resp_val && net_resp_rdy;
    orphan = empty && mem_resp_val;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    viol_count_d = viol_count_q;
    viol_flag_d  = viol_flag_q;
    if (viol_clear) begin
      viol_count_d = '0;
      viol_flag_d  = 1'b0;
    end else begin
      if (deny_fire && viol_count_q != 16'hFFFF) viol_count_d = viol_count_q + 16'd1;
      if (deny_fire || orphan)                   viol_flag_d  = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together
  // at the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      viol_count_q <= '0;
      viol_flag_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      viol_count_q <= viol_count_d;
      viol_flag_q  <= viol_flag_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; an empty count makes stale
  // contents unobservable, and leaving it out keeps the array as plain registers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= entry_new;
  end

  assign viol_count = viol_count_q;
  assign viol_flag  = viol_flag_q;

endmodule

// File: tb/tb_plab5_mcore_mem_acc_tagged.sv
// Self-checking bench: request-path vector table, directed ordering/full/reset
// sequences, randomized run against a queue model, and counter saturation.
module tb_plab5_mcore_mem_acc_tagged;

  localparam int O = 8, A = 32, D = 32, L = 2, DEPTH = 4;
  localparam int CW = 3 + O + A + 2;
  localparam int RW = 3 + O + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [L-1:0]  req_sec_level, mem_sec_level;
  logic [CW-1:0] net_req_control, mem_req_control;
  logic [D-1:0]  net_req_data, mem_req_data;
  logic          net_req_val, net_req_rdy, mem_req_val, mem_req_rdy;
  logic [RW-1:0] mem_resp_control, net_resp_control;
  logic [D-1:0]  mem_resp_data, net_resp_data;
  logic          mem_resp_val, mem_resp_rdy, net_resp_val, net_resp_rdy;
  logic [L-1:0]  resp_sec_level;
  logic [15:0]   viol_count;
  logic          viol_flag, viol_clear;

  int n_checks = 0;
  int n_pass   = 0;

  plab5_mcore_mem_acc_tagged dut (
    .clk(clk), .reset(reset),
    .req_sec_level(req_sec_level), .mem_sec_level(mem_sec_level),
    .net_req_control(net_req_control), .net_req_data(net_req_data),
    .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
    .mem_req_control(mem_req_control), .mem_req_data(mem_req_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .net_resp_control(net_resp_control), .net_resp_data(net_resp_data),
    .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
    .resp_sec_level(resp_sec_level), .viol_count(viol_count),
    .viol_flag(viol_flag), .viol_clear(viol_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [CW-1:0] mk_req(input logic [2:0] t, input logic [O-1:0] op,
                                           input logic [A-1:0] ad, input logic [1:0] ln);
    return {t, op, ad, ln};
  endfunction

  function automatic logic [RW-1:0] mk_resp(input logic [2:0] t, input logic [O-1:0] op,
                                            input logic [1:0] ln);
    return {t, op, ln};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    net_req_val = 0; net_req_control = '0; net_req_data = '0; mem_req_rdy = 0;
    mem_resp_val = 0; mem_resp_control = '0; mem_resp_data = '0;
    net_resp_rdy = 0; viol_clear = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    reset = 0;
    tick();
  endtask

  typedef struct {
    logic [L-1:0] req_l;
    logic [L-1:0] mem_l;
    logic         mrdy;
    logic         exp_mval;
    logic         exp_nrdy;
  } vec_t;

  typedef struct {
    bit            g;
    logic [L-1:0]  lvl;
    logic [RW-1:0] rctl;
  } pend_t;

  initial begin
    vec_t          vecs[8];
    pend_t         q[$];
    pend_t         e;
    logic [O-1:0]  got[3];
    int            n_got, mem_idx, m_cnt;
    bit            m_flag, g, full, empty, push, pop, exp_rval, exp_nrdy;
    logic [CW-1:0] c;

    reset = 1; req_sec_level = 0; mem_sec_level = 0; idle();
    #12 reset = 0;
    tick();

    // Reset state
    check("rst_net_resp_val", net_resp_val, 0);
    check("rst_mem_resp_rdy", mem_resp_rdy, 0);
    check("rst_mem_req_val", mem_req_val, 0);
    check("rst_viol_count", viol_count, 0);
    check("rst_viol_flag", viol_flag, 0);
    check("rst_resp_sec_level", resp_sec_level, 0);

    // Request-path decision table (FIFO empty, valid withdrawn before the edge)
    vecs[0] = '{2'd0, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{2'd3, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 2'd3, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'd3, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'd1, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{2'd3, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{2'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      req_sec_level = vecs[i].req_l; mem_sec_level = vecs[i].mem_l;
      mem_req_rdy = vecs[i].mrdy;
      c = mk_req(3'(i), 8'(8'h40 + i), 32'hA000_0000 + 32'(i), 2'(i));
      net_req_control = c; net_req_data = 32'h1234_0000 + 32'(i); net_req_val = 1;
      #1;
      check($sformatf("vec%0d_mem_req_val", i), mem_req_val, vecs[i].exp_mval);
      check($sformatf("vec%0d_net_req_rdy", i), net_req_rdy, vecs[i].exp_nrdy);
      check($sformatf("vec%0d_mem_req_control", i), mem_req_control, vecs[i].exp_mval ? c : '0);
      check($sformatf("vec%0d_mem_req_data", i), mem_req_data,
            vecs[i].exp_mval ? 32'h1234_0000 + 32'(i) : 32'h0);
      net_req_val = 0;
      tick();
    end

    // Equal levels, granted read returns memory data
    idle(); req_sec_level = 1; mem_sec_level = 1;
    c = mk_req(3'd0, 8'h05, 32'h100, 2'd0);
    net_req_control = c; net_req_val = 1; mem_req_rdy = 1;
    #1;
    check("eq_mem_req_val", mem_req_val, 1);
    check("eq_mem_req_control", mem_req_control, c);
    tick();
    net_req_val = 0; mem_resp_val = 1; mem_resp_control = mk_resp(3'd0, 8'h05, 2'd0);
    mem_resp_data = 32'hCAFE; net_resp_rdy = 1;
    #1;
    check("eq_net_resp_val", net_resp_val, 1);
    check("eq_net_resp_data", net_resp_data, 32'hCAFE);
    check("eq_net_resp_opaque", net_resp_control[9:2], 8'h05);
    check("eq_resp_sec_level", resp_sec_level, 1);
    check("eq_mem_resp_rdy", mem_resp_rdy, 1);
    tick();
    mem_resp_val = 0;
    #1;
    check("eq_empty_after_pop", net_resp_val, 0);
    check("eq_empty_sec_level", resp_sec_level, 0);

    // Low requester denied
    idle(); req_sec_level = 0; mem_sec_level = 2;
    net_req_control = mk_req(3'd1, 8'h11, 32'h200, 2'd1); net_req_data = 32'h5555;
    net_req_val = 1;
    #1;
    check("deny_mem_req_val", mem_req_val, 0);
    check("deny_mem_req_control", mem_req_control, 0);
    check("deny_mem_req_data", mem_req_data, 0);
    check("deny_net_req_rdy", net_req_rdy, 1);
    tick();
    net_req_val = 0;
    #1;
    check("deny_net_resp_val", net_resp_val, 1);
    check("deny_net_resp_control", net_resp_control, mk_resp(3'd1, 8'h11, 2'd1));
    check("deny_net_resp_data", net_resp_data, 0);
    check("deny_mem_resp_rdy", mem_resp_rdy, 0);
    check("deny_viol_count", viol_count, 1);
    check("deny_viol_flag", viol_flag, 1);
    net_resp_rdy = 1;
    tick();
    net_resp_rdy = 0; viol_clear = 1;
    check("deny_popped", net_resp_val, 0);
    tick();
    viol_clear = 0;
    check("clear_viol_count", viol_count, 0);
    check("clear_viol_flag", viol_flag, 0);

    // Level change after push does not affect the queued entry
    idle(); req_sec_level = 1; mem_sec_level = 1;
    net_req_control = mk_req(3'd0, 8'h21, 32'h300, 2'd0); net_req_val = 1; mem_req_rdy = 1;
    tick();
    net_req_val = 0; mem_sec_level = 3; net_resp_rdy = 1;
    #1;
    check("lvlchg_waits_mem", net_resp_val, 0);
    check("lvlchg_mem_resp_rdy", mem_resp_rdy, 1);
    mem_resp_val = 1; mem_resp_control = mk_resp(3'd0, 8'h21, 2'd0);
    #1;
    check("lvlchg_passthru", net_resp_val, 1);
    tick();
    mem_resp_val = 0;
    check("lvlchg_no_viol", viol_count, 0);

    // Ordering with a memory stall on the first granted request
    idle(); mem_sec_level = 1; mem_req_rdy = 1; net_req_val = 1;
    req_sec_level = 1; net_req_control = mk_req(3'd0, 8'h01, 32'h0, 2'd0); tick();
    req_sec_level = 0; net_req_control = mk_req(3'd0, 8'h02, 32'h0, 2'd0); tick();
    req_sec_level = 1; net_req_control = mk_req(3'd0, 8'h03, 32'h0, 2'd0); tick();
    net_req_val = 0; net_resp_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      check("order_stall_hold", net_resp_val, 0);
      tick();
    end
    n_got = 0; mem_idx = 0;
    for (int i = 0; i < 20 && n_got < 3; i++) begin
      mem_resp_val = mem_idx < 2;
      mem_resp_control = mk_resp(3'd0, (mem_idx == 0) ? 8'h01 : 8'h03, 2'd0);
      #1;
      if (net_resp_val && net_resp_rdy) begin
        got[n_got] = net_resp_control[9:2];
        n_got++;
      end
      if (mem_resp_val && mem_resp_rdy) mem_idx++;
      @(posedge clk);
      #1;
    end
    mem_resp_val = 0;
    check("order_count", n_got, 3);
    for (int i = 0; i < n_got; i++) check($sformatf("order_%0d", i), got[i], i + 1);

    // Full FIFO, no bypass during the pop cycle
    idle(); req_sec_level = 1; mem_sec_level = 0; mem_req_rdy = 1; net_req_val = 1;
    for (int i = 0; i < DEPTH; i++) begin
      net_req_control = mk_req(3'd0, 8'(8'h60 + i), 32'h0, 2'd0);
      tick();
    end
    #1;
    check("full_net_req_rdy", net_req_rdy, 0);
    check("full_mem_req_val", mem_req_val, 0);
    mem_resp_val = 1; net_resp_rdy = 1;
    #1;
    check("full_pop_resp_val", net_resp_val, 1);
    check("full_pop_net_req_rdy", net_req_rdy, 0);
    check("full_pop_mem_req_val", mem_req_val, 0);
    tick();
    net_req_val = 0;
    check("after_pop_net_req_rdy", net_req_rdy, 1);
    repeat (DEPTH - 1) tick();
    mem_resp_val = 0;
    #1;
    check("full_drained", net_resp_val, 0);

    // Reset mid-flight
    idle(); mem_sec_level = 1; mem_req_rdy = 1; net_req_val = 1;
    req_sec_level = 0; net_req_control = mk_req(3'd2, 8'h71, 32'h0, 2'd0); tick();
    req_sec_level = 1; net_req_control = mk_req(3'd2, 8'h72, 32'h0, 2'd0); tick();
    net_req_val = 0;
    #1;
    check("mid_pre_reset_val", net_resp_val, 1);
    reset = 1;
    #1;
    check("mid_reset_resp_val", net_resp_val, 0);
    check("mid_reset_viol_count", viol_count, 0);
    check("mid_reset_mem_resp_rdy", mem_resp_rdy, 0);
    #1 reset = 0;
    mem_resp_val = 1; net_resp_rdy = 1;
    #1;
    check("mid_orphan_mem_resp_rdy", mem_resp_rdy, 0);
    check("mid_orphan_resp_val", net_resp_val, 0);
    tick();
    mem_resp_val = 0;
    check("mid_orphan_flag", viol_flag, 1);

    // Randomized run against a queue-based model
    idle(); do_reset();
    q.delete(); m_cnt = 0; m_flag = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      req_sec_level = L'($urandom); mem_sec_level = L'($urandom);
      net_req_val = $urandom_range(0, 1);
      net_req_control = {$urandom, $urandom};
      net_req_data = $urandom;
      mem_req_rdy = $urandom_range(0, 3) != 0;
      mem_resp_val = $urandom_range(0, 1);
      mem_resp_control = RW'($urandom);
      mem_resp_data = $urandom;
      net_resp_rdy = $urandom_range(0, 1);
      viol_clear = $urandom_range(0, 15) == 0;
      #1;
      g = req_sec_level >= mem_sec_level;
      full = q.size() == DEPTH;
      empty = q.size() == 0;
      exp_nrdy = !full && (!g || mem_req_rdy);
      check("rnd_net_req_rdy", net_req_rdy, exp_nrdy);
      check("rnd_mem_req_val", mem_req_val, net_req_val && g && !full);
      check("rnd_mem_req_control", mem_req_control, g ? net_req_control : '0);
      check("rnd_mem_req_data", mem_req_data, g ? net_req_data : '0);
      if (empty) begin
        exp_rval = 0;
        check("rnd_empty_resp_val", net_resp_val, 0);
        check("rnd_empty_resp_data", net_resp_data, 0);
        check("rnd_empty_mem_resp_rdy", mem_resp_rdy, 0);
        check("rnd_empty_sec_level", resp_sec_level, 0);
      end else begin
        e = q[0];
        check("rnd_sec_level", resp_sec_level, e.lvl);
        if (e.g) begin
          exp_rval = mem_resp_val;
          check("rnd_g_resp_val", net_resp_val, mem_resp_val);
          check("rnd_g_resp_control", net_resp_control, mem_resp_control);
          check("rnd_g_resp_data", net_resp_data, mem_resp_data);
          check("rnd_g_mem_resp_rdy", mem_resp_rdy, net_resp_rdy);
        end else begin
          exp_rval = 1;
          check("rnd_d_resp_val", net_resp_val, 1);
          check("rnd_d_resp_control", net_resp_control, e.rctl);
          check("rnd_d_resp_data", net_resp_data, 0);
          check("rnd_d_mem_resp_rdy", mem_resp_rdy, 0);
        end
      end
      check("rnd_viol_count", viol_count, m_cnt);
      check("rnd_viol_flag", viol_flag, m_flag);
      push = net_req_val && exp_nrdy;
      pop = exp_rval && net_resp_rdy;
      if (viol_clear) begin
        m_cnt = 0; m_flag = 0;
      end else begin
        if (push && !g) begin
          if (m_cnt < 65535) m_cnt++;
          m_flag = 1;
        end
        if (empty && mem_resp_val) m_flag = 1;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        e.g = g; e.lvl = req_sec_level;
        e.rctl = {net_req_control[CW-1 -: 3], net_req_control[A+2 +: O], net_req_control[1:0]};
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end

    // Counter saturation and clear priority
    idle(); do_reset();
    req_sec_level = 0; mem_sec_level = 3; net_req_val = 1; net_resp_rdy = 1;
    repeat (65537) @(posedge clk);
    #1;
    check("sat_viol_count", viol_count, 16'hFFFF);
    check("sat_viol_flag", viol_flag, 1);
    viol_clear = 1;
    tick();
    viol_clear = 0;
    check("sat_clear_count", viol_count, 0);
    check("sat_clear_flag", viol_flag, 0);
    net_req_val = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
